// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
// Holds the FSM encoding, field width and the wrap-around increment helper.
package stopwatch_pkg;

   localparam int unsigned FieldW        = 6;
   localparam int unsigned MaxValDefault = 59;

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StPaused = 2'd1,
      StAdjust = 2'd2
   } state_e;

   // Compare-then-increment; anything at or above the limit folds back to zero.
   function automatic logic [FieldW-1:0] wrap_inc(input logic [FieldW-1:0] val,
                                                  input logic [FieldW-1:0] max_val);
      return (val >= max_val) ? '0 : val + FieldW'(1);
   endfunction

endpackage

// File: rtl/stopwatch_counter_tick_gen.sv
// Free-running prescaler producing single-cycle 1 Hz / 2 Hz enables and the
// 1 Hz blink square wave, all on the system clock.
module tick_gen #(
   parameter int unsigned CLK_HZ = 100000000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_1hz,
   output logic tick_2hz,
   output logic blink
);

   localparam int unsigned QuarterCnt = CLK_HZ / 4;
   localparam int unsigned CntW       = (QuarterCnt > 1) ? $clog2(QuarterCnt) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(QuarterCnt - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      phase_q, phase_d;
   logic            blink_q, blink_d;
   logic            quarter;

   always_comb begin
      quarter  = (cnt_q == CntLast);
      cnt_d    = quarter ? '0 : cnt_q + CntW'(1);
      phase_d  = quarter ? phase_q + 2'd1 : phase_q;
      // Odd phases give two pulses per second; phase 3 is the once-a-second one.
      tick_2hz = quarter & phase_q[0];
      tick_1hz = quarter & (phase_q == 2'd3);
      blink_d  = blink_q ^ tick_2hz;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         phase_q <= 2'd0;
         blink_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         blink_q <= blink_d;
      end
   end

   assign blink = blink_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping core: run/pause/adjust FSM plus the min:sec counters,
// clocked by one clock and advanced by enables from tick_gen.
module stopwatch_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 100000000,
   parameter int unsigned MAX_VAL = MaxValDefault
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pause,
   input  logic              clr,
   input  logic              adj,
   input  logic              sel,
   output logic [FieldW-1:0] min,
   output logic [FieldW-1:0] sec,
   output logic              paused,
   output logic              blink
);

   localparam logic [FieldW-1:0] MaxV = FieldW'(MAX_VAL);

   state_e            state_q, state_d;
   logic [FieldW-1:0] min_q, min_d;
   logic [FieldW-1:0] sec_q, sec_d;
   logic              pause_q;
   logic              paused_q, paused_d;
   logic              pause_rise;
   logic              tick_1hz, tick_2hz;

   tick_gen #(
      .CLK_HZ (CLK_HZ)
   ) u_tick_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_1hz (tick_1hz),
      .tick_2hz (tick_2hz),
      .blink    (blink)
   );

   assign pause_rise = pause & ~pause_q;
   assign paused_d   = paused_q ^ pause_rise;

   always_comb begin
      state_d = state_q;
      if (adj) begin
         state_d = StAdjust;
      end else begin
         unique case (state_q)
            StRun:    if (paused_q)  state_d = StPaused;
            StPaused: if (!paused_q) state_d = StRun;
            StAdjust: state_d = paused_q ? StPaused : StRun;
            default:  state_d = StRun;
         endcase
      end
   end

   always_comb begin
      min_d = min_q;
      sec_d = sec_q;
      if (clr) begin
         min_d = '0;
         sec_d = '0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (tick_1hz) begin
                  sec_d = wrap_inc(sec_q, MaxV);
                  if (sec_q >= MaxV) min_d = wrap_inc(min_q, MaxV);
               end
            end
            // Adjust bumps only the selected field, with no carry.
            StAdjust: begin
               if (tick_2hz) begin
                  if (sel) sec_d = wrap_inc(sec_q, MaxV);
                  else     min_d = wrap_inc(min_q, MaxV);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StRun;
         min_q    <= '0;
         sec_q    <= '0;
         pause_q  <= 1'b0;
         paused_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         min_q    <= min_d;
         sec_q    <= sec_d;
         pause_q  <= pause;
         paused_q <= paused_d;
      end
   end

   assign min    = min_q;
   assign sec    = sec_q;
   assign paused = paused_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter at CLK_HZ=8 (1 s = 8 clk, blink period 8 clk).
module tb_stopwatch_counter;

   logic       clk = 1'b0;
   logic       rst_n, pause, clr, adj, sel;
   logic [5:0] min, sec;
   logic       paused, blink;

   int n_cmp = 0;
   int n_err = 0;

   stopwatch_counter #(
      .CLK_HZ  (8),
      .MAX_VAL (59)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .pause  (pause),
      .clr    (clr),
      .adj    (adj),
      .sel    (sel),
      .min    (min),
      .sec    (sec),
      .paused (paused),
      .blink  (blink)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic       pause;
      logic       clr;
      logic       adj;
      logic       sel;
      int         ncyc;
      logic [5:0] emin;
      logic [5:0] esec;
      logic       epaused;
      logic       eblink;
      string      name;
   } vec_t;

   vec_t vecs[28];

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input int emin, input int esec,
                          input int ep, input int eb);
      chk({nm, ".min"}, int'(min), emin);
      chk({nm, ".sec"}, int'(sec), esec);
      chk({nm, ".paused"}, int'(paused), ep);
      chk({nm, ".blink"}, int'(blink), eb);
   endtask

   initial begin
      // Time at check = edges since reset; tick_1hz lands on every 8th edge,
      // blink toggles on every 4th edge.
      //         rst pau clr adj sel ncyc min sec p  b
      vecs[0]  = '{1, 0, 1, 0, 0,   1,  0,  0, 0, 0, "clr_run"};
      vecs[1]  = '{1, 0, 0, 0, 0,  39,  0,  5, 0, 0, "count_to_5"};
      vecs[2]  = '{1, 1, 0, 0, 0,   1,  0,  5, 1, 0, "pause_rise"};
      vecs[3]  = '{1, 1, 0, 0, 0,  39,  0,  5, 1, 0, "pause_held"};
      vecs[4]  = '{1, 0, 0, 0, 0,  80,  0,  5, 1, 0, "paused_hold"};
      vecs[5]  = '{1, 1, 0, 0, 0,   1,  0,  5, 0, 0, "unpause"};
      vecs[6]  = '{1, 0, 0, 0, 0,   7,  0,  6, 0, 0, "resume"};
      vecs[7]  = '{1, 0, 0, 1, 0,  12,  3,  6, 0, 1, "adj_min3"};
      vecs[8]  = '{1, 0, 0, 1, 1, 212,  3, 59, 0, 0, "adj_sec59"};
      vecs[9]  = '{1, 0, 0, 1, 1,   4,  3,  0, 0, 1, "adj_sec_wrap"};
      vecs[10] = '{1, 0, 0, 1, 0, 224, 59,  0, 0, 1, "adj_min59"};
      vecs[11] = '{1, 0, 0, 1, 1, 236, 59, 59, 0, 0, "adj_5959"};
      vecs[12] = '{1, 0, 0, 0, 0,   7, 59, 59, 0, 1, "run_pre_roll"};
      vecs[13] = '{1, 0, 0, 0, 0,   1,  0,  0, 0, 0, "rollover"};
      vecs[14] = '{1, 0, 0, 0, 0,  72,  0,  9, 0, 0, "count_to_9"};
      vecs[15] = '{1, 0, 0, 0, 0,   7,  0,  9, 0, 1, "pre_clr_tick"};
      vecs[16] = '{1, 0, 1, 0, 0,   1,  0,  0, 0, 0, "clr_on_tick"};
      vecs[17] = '{1, 0, 0, 0, 0,   8,  0,  1, 0, 0, "still_run"};
      vecs[18] = '{1, 0, 0, 1, 1,   8,  0,  3, 0, 0, "adj_sec_2"};
      vecs[19] = '{1, 0, 1, 1, 1,   1,  0,  0, 0, 0, "clr_in_adj"};
      vecs[20] = '{1, 0, 0, 1, 1,   3,  0,  1, 0, 1, "still_adj"};
      vecs[21] = '{1, 0, 0, 1, 0,  48, 12,  1, 0, 1, "adj_min12"};
      vecs[22] = '{1, 0, 0, 1, 1, 132, 12, 34, 0, 0, "adj_1234"};
      vecs[23] = '{1, 1, 0, 1, 1,   1, 12, 34, 1, 0, "pause_in_adj"};
      vecs[24] = '{1, 0, 0, 1, 1,   2, 12, 34, 1, 0, "adj_paused"};
      vecs[25] = '{0, 0, 0, 1, 1,   1,  0,  0, 0, 0, "reset_in_adj"};
      vecs[26] = '{1, 0, 0, 0, 0,   4,  0,  0, 0, 1, "post_rst_blink"};
      vecs[27] = '{1, 0, 0, 0, 0,   4,  0,  1, 0, 0, "post_rst_run"};

      rst_n = 1'b0;
      pause = 1'b0;
      clr   = 1'b0;
      adj   = 1'b0;
      sel   = 1'b0;
      step(3);
      rst_n = 1'b1;
      chk_all("reset", 0, 0, 0, 0);

      // 61 seconds of free running: sec 1..59, wrap to 0 with min=1, then 01:01.
      for (int i = 1; i <= 61; i++) begin
         step(4);
         chk($sformatf("run%0d.blink_hi", i), int'(blink), 1);
         step(4);
         chk_all($sformatf("run%0d", i), (i >= 60) ? 1 : 0, (i >= 60) ? i - 60 : i, 0, 0);
      end

      for (int v = 0; v < 28; v++) begin
         rst_n = vecs[v].rst_n;
         pause = vecs[v].pause;
         clr   = vecs[v].clr;
         adj   = vecs[v].adj;
         sel   = vecs[v].sel;
         step(vecs[v].ncyc);
         chk_all(vecs[v].name, int'(vecs[v].emin), int'(vecs[v].esec),
                 int'(vecs[v].epaused), int'(vecs[v].eblink));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
